// File: rtl/dot_nxn_stream_if.sv
// Streaming interface for dot_nxn_stream: kernel load port, window input
// handshake and result output handshake.
//   i_kernel_valid/i_kernel         : kernel write strobe and one packed kernel
//   o_kernels_loaded                : every kernel slot written since last reload
//   i_valid/o_ready/i_data          : window input handshake and packed NxN window
//   o_valid/i_ready                 : result output handshake
//   o_data/o_max/o_max_idx          : saturated per-kernel sums, channel max and its index
// Modport slave is the block side, master is the driver side.
interface dot_nxn_stream_if #(
    parameter int unsigned N             = 3,
    parameter int unsigned BitSize       = 4,
    parameter int unsigned KernelBitSize = 1,
    parameter int unsigned NumKernels    = 2,
    parameter int unsigned OutBitSize    = BitSize
) ();
    localparam int unsigned IdxW = (NumKernels > 1) ? $clog2(NumKernels) : 1;

    logic                               i_kernel_valid;
    logic [KernelBitSize*N*N-1:0]       i_kernel;
    logic                               o_kernels_loaded;
    logic                               i_valid;
    logic                               o_ready;
    logic [BitSize*N*N-1:0]             i_data;
    logic                               o_valid;
    logic                               i_ready;
    logic [NumKernels*OutBitSize-1:0]   o_data;
    logic [OutBitSize-1:0]              o_max;
    logic [IdxW-1:0]                    o_max_idx;

    modport slave (
        input  i_kernel_valid, i_kernel, i_valid, i_data, i_ready,
        output o_kernels_loaded, o_ready, o_valid, o_data, o_max, o_max_idx
    );

    modport master (
        output i_kernel_valid, i_kernel, i_valid, i_data, i_ready,
        input  o_kernels_loaded, o_ready, o_valid, o_data, o_max, o_max_idx
    );
endinterface

// File: rtl/dot_nxn_stream.sv
// Pipelined multi-kernel NxN dot product with channel-wise max.
// Holds NumKernels kernels (binary when KernelBitSize == 1, signed otherwise),
// accepts one window per cycle and emits one saturated sum per kernel plus the
// largest channel and its index, three register stages after acceptance.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   strm  : dot_nxn_stream_if slave (kernel load, window in, result out)
module dot_nxn_stream #(
    parameter int unsigned N             = 3,
    parameter int unsigned BitSize       = 4,
    parameter int unsigned KernelBitSize = 1,
    parameter int unsigned NumKernels    = 2,
    parameter int unsigned OutBitSize    = BitSize
) (
    input  logic            clk,
    input  logic            reset,
    dot_nxn_stream_if.slave strm
);
    localparam int unsigned NN    = N * N;
    // Binary mode also lands on BitSize+1 since KernelBitSize is 1 there.
    localparam int unsigned ProdW = BitSize + KernelBitSize;
    localparam int unsigned AccW  = ProdW + $clog2(NN);
    localparam int unsigned IdxW  = (NumKernels > 1) ? $clog2(NumKernels) : 1;
    localparam int unsigned CmpW  = (AccW > OutBitSize) ? AccW : OutBitSize;
    localparam logic signed [CmpW-1:0] SatMax = CmpW'((64'sd1 <<< (OutBitSize - 1)) - 64'sd1);
    localparam logic signed [CmpW-1:0] SatMin = ~SatMax;

    logic [KernelBitSize*NN-1:0] kern_q [NumKernels];
    logic [IdxW-1:0]             wr_ptr_q;
    logic                        loaded_q;

    logic s1_valid_q, s2_valid_q, s3_valid_q;
    logic en, ready, accept;

    logic signed [ProdW-1:0]      prod_d [NumKernels][NN];
    logic signed [ProdW-1:0]      prod_q [NumKernels][NN];
    logic signed [AccW-1:0]       row_d  [NumKernels][N];
    logic signed [AccW-1:0]       row_q  [NumKernels][N];
    logic signed [CmpW-1:0]       tot;
    logic signed [OutBitSize-1:0] sat_d  [NumKernels];
    logic signed [OutBitSize-1:0] sat_q  [NumKernels];
    logic signed [OutBitSize-1:0] max_d, max_q;
    logic [IdxW-1:0]              idx_d, idx_q;

    assign en     = !s3_valid_q || strm.i_ready;
    assign ready  = loaded_q && en;
    assign accept = strm.i_valid && ready;

    // Kernel slots. With a single slot the write both starts and completes a
    // load, so the set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NumKernels; k++) kern_q[k] <= '0;
            wr_ptr_q <= '0;
            loaded_q <= 1'b0;
        end else if (strm.i_kernel_valid) begin
            kern_q[wr_ptr_q] <= strm.i_kernel;
            if (wr_ptr_q == IdxW'(NumKernels - 1)) begin
                wr_ptr_q <= '0;
                loaded_q <= 1'b1;
            end else begin
                wr_ptr_q <= wr_ptr_q + IdxW'(1);
                if (wr_ptr_q == '0) loaded_q <= 1'b0;
            end
        end
    end

    // Products use the kernel values from before this edge.
    always_comb begin
        for (int k = 0; k < NumKernels; k++) begin
            for (int i = 0; i < NN; i++) begin
                if (KernelBitSize == 1) begin
                    prod_d[k][i] = kern_q[k][i] ?
                                   ProdW'($signed(strm.i_data[i*BitSize +: BitSize])) : '0;
                end else begin
                    prod_d[k][i] = ProdW'($signed(strm.i_data[i*BitSize +: BitSize]))
                                 * ProdW'($signed(kern_q[k][i*KernelBitSize +: KernelBitSize]));
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NumKernels; k++) begin
            for (int r = 0; r < N; r++) begin
                row_d[k][r] = '0;
                for (int c = 0; c < N; c++) begin
                    row_d[k][r] = row_d[k][r] + AccW'(prod_q[k][r*N + c]);
                end
            end
        end
    end

    // Saturate each total, then pick the max; strict '>' keeps the lowest index on ties.
    always_comb begin
        tot = '0;
        for (int k = 0; k < NumKernels; k++) begin
            tot = '0;
            for (int r = 0; r < N; r++) tot = tot + CmpW'(row_q[k][r]);
            sat_d[k] = (tot > SatMax) ? OutBitSize'(SatMax) :
                       (tot < SatMin) ? OutBitSize'(SatMin) : OutBitSize'(tot);
        end
        max_d = sat_d[0];
        idx_d = '0;
        for (int k = 1; k < NumKernels; k++) begin
            if (sat_d[k] > max_d) begin
                max_d = sat_d[k];
                idx_d = IdxW'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            for (int k = 0; k < NumKernels; k++) begin
                for (int i = 0; i < NN; i++) prod_q[k][i] <= '0;
                for (int r = 0; r < N; r++) row_q[k][r] <= '0;
                sat_q[k] <= '0;
            end
            max_q <= '0;
            idx_q <= '0;
        end else if (en) begin
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            // Payloads only move with a valid item; bubbles leave them untouched.
            if (accept)     prod_q <= prod_d;
            if (s1_valid_q) row_q  <= row_d;
            if (s2_valid_q) begin
                sat_q <= sat_d;
                max_q <= max_d;
                idx_q <= idx_d;
            end
        end
    end

    always_comb begin
        strm.o_data = '0;
        for (int k = 0; k < NumKernels; k++) begin
            strm.o_data[k*OutBitSize +: OutBitSize] = sat_q[k];
        end
    end

    assign strm.o_valid          = s3_valid_q;
    assign strm.o_ready          = ready;
    assign strm.o_kernels_loaded = loaded_q;
    assign strm.o_max            = max_q;
    assign strm.o_max_idx        = idx_q;
endmodule

// File: tb/tb_dot_nxn_stream.sv
// Bench for dot_nxn_stream: a binary-weight instance (K=1) driven through a
// scoreboard of saturated integer dot products, and a signed-weight instance (K=2)
// checked at fixed latency.
module tb_dot_nxn_stream;
    typedef struct {
        int d0;
        int d1;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_ret    = 0;

    int   kb [2][9];
    int   mb_ptr = 0;
    bit   mb_loaded = 1'b0;
    exp_t exp_q[$];
    int   win [9];

    always #5 clk = ~clk;

    dot_nxn_stream_if #(.N(3), .BitSize(4), .KernelBitSize(1), .NumKernels(2), .OutBitSize(4))
        bb ();
    dot_nxn_stream_if #(.N(3), .BitSize(4), .KernelBitSize(2), .NumKernels(2), .OutBitSize(4))
        ss ();

    dot_nxn_stream #(.N(3), .BitSize(4), .KernelBitSize(1), .NumKernels(2), .OutBitSize(4))
        u_bin (.clk(clk), .reset(reset), .strm(bb));
    dot_nxn_stream #(.N(3), .BitSize(4), .KernelBitSize(2), .NumKernels(2), .OutBitSize(4))
        u_sgn (.clk(clk), .reset(reset), .strm(ss));

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int dot_sat(input int w[9], input int x[9]);
        int s = 0;
        for (int i = 0; i < 9; i++) s += w[i] * x[i];
        if (s > 7) return 7;
        if (s < -8) return -8;
        return s;
    endfunction

    task automatic set_win_b(input bit v);
        bb.i_valid = v;
        for (int i = 0; i < 9; i++) bb.i_data[i*4 +: 4] = 4'(win[i]);
    endtask

    // One clock of the binary instance: checks the handshake against the model,
    // scores retired outputs, records accepted windows and kernel writes.
    task automatic step_b(output bit acc);
        bit         ret, hold;
        logic [7:0] sv_data;
        logic [3:0] sv_max;
        exp_t       e;
        int         emax, eidx;
        #1;
        check("kloaded", bb.o_kernels_loaded, mb_loaded);
        check("ready", bb.o_ready, mb_loaded && (!bb.o_valid || bb.i_ready));
        acc     = bb.i_valid && bb.o_ready;
        ret     = bb.o_valid && bb.i_ready;
        hold    = bb.o_valid && !bb.i_ready;
        sv_data = bb.o_data;
        sv_max  = bb.o_max;
        if (ret) begin
            n_ret++;
            check("out_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e    = exp_q.pop_front();
                emax = (e.d1 > e.d0) ? e.d1 : e.d0;
                eidx = (e.d1 > e.d0) ? 1 : 0;
                check("data0", $signed(bb.o_data[3:0]), e.d0);
                check("data1", $signed(bb.o_data[7:4]), e.d1);
                check("max", $signed(bb.o_max), emax);
                check("max_idx", bb.o_max_idx, eidx);
            end
        end
        if (acc) begin
            e.d0 = dot_sat(kb[0], win);
            e.d1 = dot_sat(kb[1], win);
            exp_q.push_back(e);
        end
        if (bb.i_kernel_valid) begin
            for (int i = 0; i < 9; i++) kb[mb_ptr][i] = int'(bb.i_kernel[i]);
            mb_loaded = (mb_ptr == 1);
            mb_ptr    = (mb_ptr + 1) % 2;
        end
        @(posedge clk);
        #1;
        if (hold) begin
            check("hold_valid", bb.o_valid, 1);
            check("hold_data", bb.o_data, sv_data);
            check("hold_max", bb.o_max, sv_max);
        end
    endtask

    task automatic load_b(input logic [8:0] k);
        bit a;
        bb.i_kernel_valid = 1'b1;
        bb.i_kernel       = k;
        step_b(a);
        bb.i_kernel_valid = 1'b0;
    endtask

    task automatic drain_b();
        bit a;
        bb.i_valid        = 1'b0;
        bb.i_kernel_valid = 1'b0;
        bb.i_ready        = 1'b1;
        repeat (5) step_b(a);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit          a;
        int          cnt, nw, start_ret;
        int          bp_win [5][9];
        int          ks [2][9];
        int          xs [9];
        logic [17:0] kv0, kv1;
        int          e0, e1, em, ei;

        bb.i_valid = 1'b0; bb.i_data = '0; bb.i_kernel_valid = 1'b0; bb.i_kernel = '0;
        bb.i_ready = 1'b1;
        ss.i_valid = 1'b0; ss.i_data = '0; ss.i_kernel_valid = 1'b0; ss.i_kernel = '0;
        ss.i_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bb.o_valid, 0);
        check("rst_ready", bb.o_ready, 0);
        check("rst_loaded", bb.o_kernels_loaded, 0);
        check("rst_data", bb.o_data, 0);
        check("rst_max", bb.o_max, 0);
        check("rst_idx", bb.o_max_idx, 0);
        check("rst_sgn_valid", ss.o_valid, 0);
        reset = 1'b0;

        // Window offered before any kernel load must be ignored.
        win = '{4, -4, 2, -4, 2, 4, 2, 4, -4};
        set_win_b(1'b1);
        repeat (2) step_b(a);
        set_win_b(1'b0);
        load_b(9'b101010001);
        load_b(9'h1FF);

        // Basic binary product and three-stage latency.
        set_win_b(1'b1);
        step_b(a);
        check("lat_acc", a, 1);
        set_win_b(1'b0);
        check("lat_e0", bb.o_valid, 0);
        step_b(a);
        check("lat_e1", bb.o_valid, 0);
        step_b(a);
        check("lat_e2", bb.o_valid, 1);
        check("bin_ch0", $signed(bb.o_data[3:0]), 4);
        check("bin_ch1", $signed(bb.o_data[7:4]), 6);
        check("bin_max", $signed(bb.o_max), 6);
        check("bin_idx", bb.o_max_idx, 1);

        // Saturation both ways, back to back.
        for (int i = 0; i < 9; i++) win[i] = 7;
        set_win_b(1'b1);
        step_b(a);
        for (int i = 0; i < 9; i++) win[i] = -8;
        set_win_b(1'b1);
        step_b(a);
        set_win_b(1'b0);
        step_b(a);
        check("sat_pos_valid", bb.o_valid, 1);
        check("sat_pos_ch1", $signed(bb.o_data[7:4]), 7);
        check("sat_pos_idx", bb.o_max_idx, 0);
        step_b(a);
        check("sat_neg_ch0", $signed(bb.o_data[3:0]), -8);
        check("sat_neg_ch1", $signed(bb.o_data[7:4]), -8);
        drain_b();

        // Backpressure: five windows with a four-cycle stall in the middle.
        for (int w = 0; w < 5; w++)
            for (int i = 0; i < 9; i++) bp_win[w][i] = int'($urandom_range(15)) - 8;
        start_ret = n_ret;
        nw  = 0;
        cnt = 0;
        while (nw < 5 && cnt < 40) begin
            win = bp_win[nw];
            set_win_b(1'b1);
            bb.i_ready = !(cnt >= 3 && cnt < 7);
            step_b(a);
            if (a) nw++;
            cnt++;
        end
        check("bp_all_accepted", nw, 5);
        drain_b();
        check("bp_out_count", n_ret - start_ret, 5);

        // Random traffic with random backpressure and occasional kernel writes.
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < 9; i++) win[i] = int'($urandom_range(15)) - 8;
            set_win_b($urandom_range(3) != 0);
            bb.i_ready        = ($urandom_range(3) != 0);
            bb.i_kernel_valid = ($urandom_range(9) == 0);
            bb.i_kernel       = 9'($urandom);
            step_b(a);
        end
        bb.i_kernel_valid = 1'b0;
        if (mb_ptr != 0) load_b(9'($urandom));
        drain_b();

        // Reload: window accepted together with a write to slot 0 uses the old kernel.
        load_b(9'b101010001);
        load_b(9'h1FF);
        for (int i = 0; i < 9; i++) win[i] = 1;
        set_win_b(1'b1);
        bb.i_kernel_valid = 1'b1;
        bb.i_kernel       = 9'h000;
        step_b(a);
        check("rl_acc", a, 1);
        bb.i_kernel_valid = 1'b0;
        set_win_b(1'b0);
        #1;
        check("rl_ready_low", bb.o_ready, 0);
        step_b(a);
        step_b(a);
        check("rl_valid", bb.o_valid, 1);
        check("rl_old_kernel", $signed(bb.o_data[3:0]), 4);
        check("rl_ch1", $signed(bb.o_data[7:4]), 7);
        check("rl_loaded_low", bb.o_kernels_loaded, 0);
        set_win_b(1'b1);
        step_b(a);
        check("rl_ignored", a, 0);
        set_win_b(1'b0);
        load_b(9'h1FF);
        check("rl_loaded_high", bb.o_kernels_loaded, 1);
        drain_b();

        // Asynchronous reset between edges with windows in flight.
        for (int i = 0; i < 9; i++) win[i] = int'($urandom_range(15)) - 8;
        set_win_b(1'b1);
        step_b(a);
        step_b(a);
        set_win_b(1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", bb.o_valid, 0);
        check("arst_loaded", bb.o_kernels_loaded, 0);
        check("arst_ready", bb.o_ready, 0);
        check("arst_data", bb.o_data, 0);
        exp_q.delete();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 9; i++) kb[k][i] = 0;
        mb_ptr    = 0;
        mb_loaded = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 9; i++) win[i] = int'($urandom_range(15)) - 8;
            set_win_b(1'b1);
            step_b(a);
            check("arst_no_out", bb.o_valid, 0);
        end
        set_win_b(1'b0);
        load_b(9'($urandom));
        load_b(9'($urandom));
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 9; i++) win[i] = int'($urandom_range(15)) - 8;
            set_win_b(1'b1);
            step_b(a);
        end
        drain_b();

        // Signed weights: kernel0 all -2, kernel1 all +1, window all 1.
        ss.i_kernel_valid = 1'b1;
        ss.i_kernel       = 18'h2AAAA;
        @(posedge clk);
        #1;
        ss.i_kernel = 18'h15555;
        @(posedge clk);
        #1;
        ss.i_kernel_valid = 1'b0;
        check("sg_loaded", ss.o_kernels_loaded, 1);
        ss.i_data  = 36'h111111111;
        ss.i_valid = 1'b1;
        #1;
        check("sg_ready", ss.o_ready, 1);
        @(posedge clk);
        #1;
        ss.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("sg_valid", ss.o_valid, 1);
        check("sg_ch0", $signed(ss.o_data[3:0]), -8);
        check("sg_ch1", $signed(ss.o_data[7:4]), 7);
        check("sg_max", $signed(ss.o_max), 7);
        check("sg_idx", ss.o_max_idx, 1);

        // Random signed kernels and windows, one at a time.
        for (int t = 0; t < 6; t++) begin
            kv0 = 18'($urandom);
            kv1 = 18'($urandom);
            for (int i = 0; i < 9; i++) begin
                ks[0][i] = int'($signed(kv0[i*2 +: 2]));
                ks[1][i] = int'($signed(kv1[i*2 +: 2]));
                xs[i]    = int'($urandom_range(15)) - 8;
                ss.i_data[i*4 +: 4] = 4'(xs[i]);
            end
            ss.i_kernel_valid = 1'b1;
            ss.i_kernel       = kv0;
            @(posedge clk);
            #1;
            ss.i_kernel = kv1;
            @(posedge clk);
            #1;
            ss.i_kernel_valid = 1'b0;
            ss.i_valid        = 1'b1;
            #1;
            check("sgr_ready", ss.o_ready, 1);
            @(posedge clk);
            #1;
            ss.i_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            e0 = dot_sat(ks[0], xs);
            e1 = dot_sat(ks[1], xs);
            em = (e1 > e0) ? e1 : e0;
            ei = (e1 > e0) ? 1 : 0;
            check("sgr_valid", ss.o_valid, 1);
            check("sgr_ch0", $signed(ss.o_data[3:0]), e0);
            check("sgr_ch1", $signed(ss.o_data[7:4]), e1);
            check("sgr_max", $signed(ss.o_max), em);
            check("sgr_idx", ss.o_max_idx, ei);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/dot_nxn_stream.md
# dot_nxn_stream

Pipelined, multi-kernel successor to the combinational NxN dot-product and max-pooling pair. It holds NumKernels kernels of configurable weight precision and accepts one NxN window per cycle under a valid/ready handshake. For each window it produces one saturated dot product per kernel, plus the channel-wise maximum and its index. It sits between the window generator and the pooling/activation stage of the CNN datapath.

## Interface
- N, default 3: window side; N*N elements per window.
- BitSize, default 4: signed two's-complement width of each data element.
- KernelBitSize, default 1: weight width. A value of 1 selects binary mode (bit 1 passes x, bit 0 gives 0). A value of 2 or more selects signed two's-complement weights.
- NumKernels, default 2: number of parallel kernels/output channels, 1 or more.
- OutBitSize, default BitSize: signed width of each output sum after saturation.
- clk, in, 1: clock. All state is on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- i_kernel_valid, in, 1: kernel write strobe.
- i_kernel, in, KernelBitSize*N*N: one kernel. Weight i is i_kernel[i*KernelBitSize +: KernelBitSize].
- o_kernels_loaded, out, 1: all NumKernels slots have been written since the last load start.
- i_valid, in, 1: input window valid.
- o_ready, out, 1: block accepts a window this cycle.
- i_data, in, BitSize*N*N: window. Element i is i_data[i*BitSize +: BitSize].
- o_valid, out, 1: output valid.
- i_ready, in, 1: downstream accepts the output.
- o_data, out, NumKernels*OutBitSize: sum for kernel k is o_data[k*OutBitSize +: OutBitSize].
- o_max, out, OutBitSize: largest o_data channel (signed).
- o_max_idx, out, max(1,$clog2(NumKernels)): index of o_max. On a tie, the lowest index wins.

## Operation
- **Kernel load:** each cycle with i_kernel_valid high, i_kernel is written to slot wr_ptr, and wr_ptr is incremented.
  - wr_ptr wraps from NumKernels-1 to 0.
  - A write at wr_ptr=0 clears o_kernels_loaded.
  - A write at wr_ptr=NumKernels-1 sets o_kernels_loaded on the next cycle.
- **Arithmetic:**
  - Product width is BitSize+KernelBitSize. Binary mode uses BitSize+1, sign-extended.
  - Accumulator width is product width + $clog2(N*N). No internal overflow is possible.
  - The final sum saturates to [-2^(OutBitSize-1), 2^(OutBitSize-1)-1].
- **Pipeline:** three stages, each with its own valid bit.
  - S1: register all N*N*NumKernels products.
  - S2: register the N row partial sums per kernel.
  - S3: register the saturated totals, o_max and o_max_idx.
- **Stall rule:**
  - en = !o_valid || i_ready. All stages advance only when en is high.
  - o_ready = o_kernels_loaded && en.
  - A window is accepted when i_valid && o_ready.
  - Bubbles propagate as cleared valid bits. When en is high, an empty S1 is loaded with valid=0.
- **Kernel/data interaction:**
  - S1 uses the kernel register values present before that edge.
  - A window accepted in the same cycle as a kernel write uses the old kernel.
  - Items already in S2/S3 are unaffected by kernel writes.
  - A reload starting at wr_ptr=0 drops o_ready from the next cycle until the load completes. Items already in flight drain normally.
- **Max:** signed comparison of the saturated values, with the lowest index winning ties. When NumKernels=1, o_max=o_data and o_max_idx=0.

## Timing
- **Reset (asynchronous):**
  - o_valid=0, all stage valids 0, wr_ptr=0, kernel registers 0.
  - o_kernels_loaded=0, o_ready=0, o_data=0, o_max=0, o_max_idx=0.
- **Latency:** a window accepted at edge t appears with o_valid=1 after edge t+2, i.e. three register stages, when there is no stall.
- **Throughput:** one window per cycle while i_ready stays high.
- **Output hold:** when o_valid=1 and i_ready=0, o_data, o_max and o_max_idx hold. o_ready=0 and all stages freeze.
- **Handshake:** an output is retired on an edge with o_valid && i_ready. In that same cycle a new window may be accepted (en=1).
- **Data-only changes:** o_data changes only when en=1.
- **Reset mid-operation:** in-flight windows and kernels are discarded. Kernels must be reloaded before o_ready rises.
- **i_valid with o_ready=0:** the window is ignored, not queued.

## Test plan
- **Basic binary dot product.** Setup: N=3, B=4, K=1, NumKernels=2. Kernel0 = 9'b101010001, kernel1 = 9'b111111111. Window elements, index 8 down to 0, = {-4,4,2,4,2,-4,2,-4,4}. Required: o_data ch0 = 4, ch1 = 6, o_max = 6, o_max_idx = 1, three cycles after acceptance.
- **Saturation.** With the all-ones kernels:
  - All elements 4'b0111 → each channel = 7 (63 saturated).
  - All elements 4'b1000 → each channel = -8 (-72 saturated).
- **Signed weights.** Setup: K=2. Kernel0 with all weights -2. All elements 1 → sum -18 saturated to -8. Kernel1 with all weights 1 → 9 saturated to 7, so o_max_idx = 1.
- **Backpressure.** Stream 5 windows with i_ready low for 4 cycles mid-stream. Required: 5 outputs in order, none lost or duplicated, and outputs stable while stalled.
- **Reload.**
  - A kernel write in the same cycle as an accepted window: that window uses the old kernel.
  - After a write at wr_ptr=0: o_ready=0 until the last slot is written, and in-flight results still emerge.
- **Async reset mid-stream.** Assert reset between clock edges. Required: o_valid=0 immediately, o_kernels_loaded=0, and no output until kernels are reloaded.
